// File: rtl/imu_accel_reader.sv
// Reads one X/Y/Z accelerometer sample from an I2C IMU by sequencing byte-level
// commands to an external I2C master, with NACK and timeout recovery via STOP.
module imu_accel_reader #(
  parameter logic [6:0]  DEV_ADDR = 7'h68,
  parameter logic [7:0]  BASE_REG = 8'h12,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic [2:0]  m_cmd_o,
  output logic [7:0]  m_wdata_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  input  logic        m_done_i,
  input  logic [7:0]  m_rdata_i,
  input  logic        m_nack_i,
  output logic [15:0] acc_x_o,
  output logic [15:0] acc_y_o,
  output logic [15:0] acc_z_o,
  output logic        sample_valid_o,
  output logic        busy_o,
  output logic [1:0]  err_o
);

  localparam logic [2:0] CMD_START     = 3'd0;
  localparam logic [2:0] CMD_WRITE     = 3'd1;
  localparam logic [2:0] CMD_READ_ACK  = 3'd2;
  localparam logic [2:0] CMD_READ_NACK = 3'd3;
  localparam logic [2:0] CMD_STOP      = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  localparam logic [3:0]  LAST_STEP = 4'd11;
  localparam logic [15:0] TMO_LAST  = TIMEOUT - 16'd1;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, DONE, ERROR, STOP_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [15:0] tmo_q, tmo_d;
  logic        stopAcc_q, stopAcc_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  shadow_q [6];
  logic [15:0] accX_q, accY_q, accZ_q;

  logic [2:0]  issueCmd;
  logic [7:0]  issueData;
  logic        isWrite, isRead, handshake, tmoHit, shadowWe;
  logic [3:0]  slot;

  // Fixed command script indexed by the step counter.
  always_comb begin
    issueCmd  = CMD_STOP;
    issueData = 8'h00;
    case (step_q)
      4'd0, 4'd3: issueCmd = CMD_START;
      4'd1: begin
        issueCmd  = CMD_WRITE;
        issueData = {DEV_ADDR, 1'b0};
      end
      4'd2: begin
        issueCmd  = CMD_WRITE;
        issueData = BASE_REG;
      end
      4'd4: begin
        issueCmd  = CMD_WRITE;
        issueData = {DEV_ADDR, 1'b1};
      end
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: issueCmd = CMD_READ_ACK;
      4'd10: issueCmd = CMD_READ_NACK;
      default: issueCmd = CMD_STOP;
    endcase
  end

  assign isWrite   = (issueCmd == CMD_WRITE);
  assign isRead    = (issueCmd == CMD_READ_ACK) || (issueCmd == CMD_READ_NACK);
  assign handshake = m_valid_o && m_ready_i;
  assign tmoHit    = (tmo_q == TMO_LAST);
  assign slot      = step_q - 4'd5;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    tmo_d     = tmo_q + 16'd1;
    stopAcc_d = stopAcc_q;
    err_d     = err_q;
    shadowWe  = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (start_i) begin
          state_d = ISSUE;
          step_d  = '0;
          err_d   = ERR_NONE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          state_d = WAIT;
          tmo_d   = '0;
        end else if (tmoHit) begin
          state_d   = STOP_ERR;
          tmo_d     = '0;
          stopAcc_d = 1'b0;
          err_d     = ERR_TMO;
        end
      end
      WAIT: begin
        if (m_done_i) begin
          tmo_d = '0;
          if (isWrite && m_nack_i) begin
            state_d   = STOP_ERR;
            stopAcc_d = 1'b0;
            err_d     = ERR_NACK;
          end else begin
            shadowWe = isRead;
            step_d   = step_q + 4'd1;
            state_d  = (step_q == LAST_STEP) ? DONE : ISSUE;
          end
        end else if (tmoHit) begin
          state_d   = STOP_ERR;
          tmo_d     = '0;
          stopAcc_d = 1'b0;
          err_d     = ERR_TMO;
        end
      end
      // First wait for the STOP to be accepted, then for its completion.
      STOP_ERR: begin
        if (!stopAcc_q) begin
          if (handshake) begin
            stopAcc_d = 1'b1;
            tmo_d     = '0;
          end else if (tmoHit) begin
            state_d = ERROR;
          end
        end else if (m_done_i || tmoHit) begin
          state_d = ERROR;
        end
      end
      DONE, ERROR: begin
        state_d = IDLE;
        step_d  = '0;
        tmo_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      step_q    <= '0;
      tmo_q     <= '0;
      stopAcc_q <= 1'b0;
      err_q     <= ERR_NONE;
      accX_q    <= '0;
      accY_q    <= '0;
      accZ_q    <= '0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      tmo_q     <= tmo_d;
      stopAcc_q <= stopAcc_d;
      err_q     <= err_d;
      for (int i = 0; i < 6; i++) begin
        if (shadowWe && (slot == i[3:0])) shadow_q[i] <= m_rdata_i;
      end
      if (state_q == DONE) begin
        accX_q <= {shadow_q[1], shadow_q[0]};
        accY_q <= {shadow_q[3], shadow_q[2]};
        accZ_q <= {shadow_q[5], shadow_q[4]};
      end
    end
  end

  // The new sample is presented straight from the shadow bytes during DONE so
  // it coincides with sample_valid; the held registers take over afterwards.
  always_comb begin
    m_valid_o      = (state_q == ISSUE) || ((state_q == STOP_ERR) && !stopAcc_q);
    m_cmd_o        = (state_q == ISSUE) ? issueCmd : CMD_STOP;
    m_wdata_o      = (state_q == ISSUE) ? issueData : 8'h00;
    sample_valid_o = (state_q == DONE);
    busy_o         = (state_q != IDLE);
    err_o          = err_q;
    acc_x_o        = accX_q;
    acc_y_o        = accY_q;
    acc_z_o        = accZ_q;
    if (state_q == DONE) begin
      acc_x_o = {shadow_q[1], shadow_q[0]};
      acc_y_o = {shadow_q[3], shadow_q[2]};
      acc_z_o = {shadow_q[5], shadow_q[4]};
    end
  end

endmodule

// File: tb/tb_imu_accel_reader.sv
// Directed, table-driven bench for imu_accel_reader with a byte-level I2C
// master model that can stall, NACK or withhold completion.
module tb_imu_accel_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  m_cmd_o;
  logic [7:0]  m_wdata_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_done_i;
  logic [7:0]  m_rdata_i;
  logic        m_nack_i;
  logic [15:0] acc_x_o, acc_y_o, acc_z_o;
  logic        sample_valid_o;
  logic        busy_o;
  logic [1:0]  err_o;

  imu_accel_reader #(
    .DEV_ADDR(7'h68),
    .BASE_REG(8'h12),
    .TIMEOUT (16'd100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .m_cmd_o       (m_cmd_o),
    .m_wdata_o     (m_wdata_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_done_i      (m_done_i),
    .m_rdata_i     (m_rdata_i),
    .m_nack_i      (m_nack_i),
    .acc_x_o       (acc_x_o),
    .acc_y_o       (acc_y_o),
    .acc_z_o       (acc_z_o),
    .sample_valid_o(sample_valid_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          readyDelay;
    int          nackIdx;
    int          withholdIdx;
    bit          spam;
    logic [47:0] bytes;
    int          expLog;
    logic [1:0]  expErr;
    int          expSamples;
    logic [15:0] expX, expY, expZ;
  } scen_t;

  int checks = 0;
  int failures = 0;

  // Master model configuration and observations.
  int          readyDelay = 0;
  int          nackIdx = -1;
  int          withholdIdx = -1;
  logic [47:0] rdBytes = '0;
  int          logCount = 0;
  logic [2:0]  logCmd [32];
  logic [7:0]  logData [32];
  int          sampCount = 0;
  logic [15:0] capX, capY, capZ;
  int          stabErr = 0;
  int          idleViol = 0;
  int          stopDelay = 0;
  int          tmoCnt = 0;
  int          doneWait = 0;
  int          holdCnt = 0;
  int          curIdx = 0;
  logic [2:0]  snapCmd, accCmd;
  logic [7:0]  snapData, accData;

  logic [2:0] expCmd [12];
  logic [7:0] expData [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master model: accepts commands after readyDelay stalled cycles, completes
  // them two cycles later, and watches sample_valid and idle output values.
  initial begin
    m_ready_i = 1'b0;
    m_done_i  = 1'b0;
    m_nack_i  = 1'b0;
    m_rdata_i = 8'h00;
    forever begin
      @(negedge clk);
      m_done_i  = 1'b0;
      m_nack_i  = 1'b0;
      m_rdata_i = 8'h00;
      if (!rst_n) begin
        m_ready_i = 1'b0;
        doneWait  = 0;
        holdCnt   = 0;
        tmoCnt    = 0;
        continue;
      end
      if (sample_valid_o) begin
        sampCount++;
        capX = acc_x_o;
        capY = acc_y_o;
        capZ = acc_z_o;
      end
      if (!m_valid_o && (m_cmd_o != 3'd4 || m_wdata_o != 8'h00)) idleViol++;
      if (tmoCnt != 0) begin
        tmoCnt++;
        if (m_valid_o) begin
          stopDelay = tmoCnt;
          tmoCnt    = 0;
        end
      end
      if (m_ready_i) begin
        m_ready_i = 1'b0;
        curIdx = logCount;
        if (logCount < 32) begin
          logCmd[logCount]  = accCmd;
          logData[logCount] = accData;
        end
        logCount++;
        if (curIdx == withholdIdx) tmoCnt = 1;
        else doneWait = 2;
      end else if (doneWait != 0) begin
        doneWait--;
        if (doneWait == 0) begin
          m_done_i = 1'b1;
          if (curIdx == nackIdx) m_nack_i = 1'b1;
          if (curIdx >= 5 && curIdx <= 10) m_rdata_i = rdBytes[8*(curIdx-5) +: 8];
        end
      end else if (m_valid_o) begin
        if (holdCnt == 0) begin
          snapCmd  = m_cmd_o;
          snapData = m_wdata_o;
        end else if (m_cmd_o != snapCmd || m_wdata_o != snapData) begin
          stabErr++;
        end
        if (holdCnt >= readyDelay) begin
          m_ready_i = 1'b1;
          accCmd    = m_cmd_o;
          accData   = m_wdata_o;
          holdCnt   = 0;
        end else begin
          holdCnt++;
        end
      end else if (holdCnt != 0) begin
        stabErr++;
        holdCnt = 0;
      end
    end
  end

  task automatic applyStimulus(input scen_t s, input string tag);
    int  cycles;
    bit  spamOff;
    logic [2:0] ec;
    logic [7:0] ed;
    logCount    = 0;
    sampCount   = 0;
    stabErr     = 0;
    idleViol    = 0;
    stopDelay   = 0;
    readyDelay  = s.readyDelay;
    nackIdx     = s.nackIdx;
    withholdIdx = s.withholdIdx;
    rdBytes     = s.bytes;
    for (int i = 0; i < 32; i++) begin
      logCmd[i]  = 3'd7;
      logData[i] = 8'hEE;
    end
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = s.spam;
    checkOutput({tag, "_busyRise"}, {31'd0, busy_o}, 32'd1);
    cycles  = 0;
    spamOff = 1'b0;
    while (busy_o && cycles < 3000) begin
      @(negedge clk);
      if (sample_valid_o) spamOff = 1'b1;
      start_i = s.spam && !spamOff;
      cycles++;
    end
    start_i = 1'b0;
    checkOutput({tag, "_busyFall"}, {31'd0, busy_o}, 32'd0);
    repeat (4) @(negedge clk);
    checkOutput({tag, "_err"}, {30'd0, err_o}, {30'd0, s.expErr});
    checkOutput({tag, "_samples"}, sampCount, s.expSamples);
    checkOutput({tag, "_accX"}, {16'd0, acc_x_o}, {16'd0, s.expX});
    checkOutput({tag, "_accY"}, {16'd0, acc_y_o}, {16'd0, s.expY});
    checkOutput({tag, "_accZ"}, {16'd0, acc_z_o}, {16'd0, s.expZ});
    checkOutput({tag, "_cmdCount"}, logCount, s.expLog);
    checkOutput({tag, "_stable"}, stabErr, 0);
    checkOutput({tag, "_idleOutputs"}, idleViol, 0);
    if (s.expSamples != 0) begin
      checkOutput({tag, "_pulseX"}, {16'd0, capX}, {16'd0, s.expX});
      checkOutput({tag, "_pulseY"}, {16'd0, capY}, {16'd0, s.expY});
      checkOutput({tag, "_pulseZ"}, {16'd0, capZ}, {16'd0, s.expZ});
    end
    if (s.withholdIdx >= 0) checkOutput({tag, "_stopDelay"}, stopDelay, 101);
    for (int i = 0; i < s.expLog && i < 12; i++) begin
      ec = expCmd[i];
      ed = expData[i];
      if (s.expErr != 2'd0 && i == s.expLog - 1) begin
        ec = 3'd4;
        ed = 8'h00;
      end
      checkOutput($sformatf("%s_cmd%0d", tag, i), {29'd0, logCmd[i]}, {29'd0, ec});
      checkOutput($sformatf("%s_data%0d", tag, i), {24'd0, logData[i]}, {24'd0, ed});
    end
  endtask

  initial begin
    scen_t scen [7];
    scen_t again;
    int    cyc;

    expCmd  = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
    expData = '{8'h00, 8'hD0, 8'h12, 8'h00, 8'hD1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    scen[0] = '{0,  -1, -1, 1'b0, 48'h9ABC_5678_1234, 12, 2'd0, 1, 16'h1234, 16'h5678, 16'h9ABC};
    scen[1] = '{20, -1, -1, 1'b0, 48'h9ABC_5678_1234, 12, 2'd0, 1, 16'h1234, 16'h5678, 16'h9ABC};
    scen[2] = '{0,  -1, -1, 1'b1, 48'h8000_7FFF_8001, 12, 2'd0, 1, 16'h8001, 16'h7FFF, 16'h8000};
    scen[3] = '{0,   1, -1, 1'b0, 48'h1111_1111_1111,  3, 2'd1, 0, 16'h8001, 16'h7FFF, 16'h8000};
    scen[4] = '{0,   4, -1, 1'b0, 48'h2222_2222_2222,  6, 2'd1, 0, 16'h8001, 16'h7FFF, 16'h8000};
    scen[5] = '{0,  -1,  7, 1'b0, 48'h3333_3333_3333,  9, 2'd2, 0, 16'h8001, 16'h7FFF, 16'h8000};
    scen[6] = '{0,  -1, -1, 1'b0, 48'h1122_3344_5566, 12, 2'd0, 1, 16'h5566, 16'h3344, 16'h1122};

    rst_n   = 1'b0;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", {31'd0, m_valid_o}, 32'd0);
    checkOutput("rst_cmd", {29'd0, m_cmd_o}, 32'd4);
    checkOutput("rst_wdata", {24'd0, m_wdata_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_err", {30'd0, err_o}, 32'd0);
    checkOutput("rst_sample", {31'd0, sample_valid_o}, 32'd0);
    checkOutput("rst_accX", {16'd0, acc_x_o}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 7; k++) applyStimulus(scen[k], $sformatf("s%0d", k));

    // Reset in the middle of the READ_ACK at step 6, then a clean transaction.
    logCount    = 0;
    readyDelay  = 0;
    nackIdx     = -1;
    withholdIdx = -1;
    rdBytes     = 48'hAAAA_AAAA_AAAA;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (logCount < 7 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("mid_reached", logCount, 7);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_valid", {31'd0, m_valid_o}, 32'd0);
    checkOutput("mid_cmd", {29'd0, m_cmd_o}, 32'd4);
    checkOutput("mid_wdata", {24'd0, m_wdata_o}, 32'd0);
    checkOutput("mid_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("mid_err", {30'd0, err_o}, 32'd0);
    checkOutput("mid_accX", {16'd0, acc_x_o}, 32'd0);
    checkOutput("mid_accZ", {16'd0, acc_z_o}, 32'd0);
    checkOutput("mid_sample", {31'd0, sample_valid_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    again = '{0, -1, -1, 1'b0, 48'hFEDC_BA98_7654, 12, 2'd0, 1, 16'h7654, 16'hBA98, 16'hFEDC};
    applyStimulus(again, "post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imu_accel_reader.md
IMU_ACCEL_READER -- requirements
Module: imu_accel_reader

Interface
REQ-001 Parameter DEV_ADDR, 7'h68, 7-bit I2C address of the IMU.
REQ-002 Parameter BASE_REG, 8'h12, first accelerometer register (ACCX_LSB); six consecutive registers are read.
REQ-003 Parameter TIMEOUT, 16'd50000, clk cycles allowed per master command before abort.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request for one X/Y/Z sample; ignored unless idle.
REQ-007 m_cmd  output  3  byte-level master command: 0 START, 1 WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP.
REQ-008 m_wdata  output  8  byte for WRITE commands, 8'h00 otherwise.
REQ-009 m_valid  output  1  command valid; held with m_cmd/m_wdata stable until accepted.
REQ-010 m_ready  input  1  master accepts the command when m_valid && m_ready.
REQ-011 m_done  input  1  single-cycle pulse: the accepted command completed.
REQ-012 m_rdata  input  8  read byte, qualified by m_done of a READ command.
REQ-013 m_nack  input  1  slave NACK, qualified by m_done of a WRITE command.
REQ-014 acc_x, acc_y, acc_z  output  16 each  signed samples, {MSB,LSB}.
REQ-015 sample_valid  output  1  single-cycle pulse: acc_x/y/z updated together.
REQ-016 busy  output  1  high from accepted start until DONE or ERROR exits.
REQ-017 err  output  2  last error: 0 none, 1 NACK, 2 timeout; cleared on next accepted start.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE, ERROR, STOP_ERR.
REQ-019 Command list per transaction, fixed order, step 0-11: START; WRITE {DEV_ADDR,0}; WRITE BASE_REG; START (repeated); WRITE {DEV_ADDR,1}; READ_ACK x5; READ_NACK; STOP.
REQ-020 IDLE -> ISSUE on start; step counter loads 0, busy rises the next cycle.
REQ-021 ISSUE: m_valid=1 with the command for the current step; on m_valid && m_ready -> WAIT, m_valid drops next cycle.
REQ-022 WAIT: on m_done, a READ step stores m_rdata into byte slot (step-5); the step increments; -> ISSUE, or -> DONE after step 11.
REQ-023 Byte slots 0..5 map to acc_x[7:0], acc_x[15:8], acc_y[7:0], acc_y[15:8], acc_z[7:0], acc_z[15:8].
REQ-024 acc_x/y/z update only in DONE, from the shadow bytes; partial reads never reach the outputs.
REQ-025 DONE: sample_valid=1 for exactly one cycle, then -> IDLE; busy low in IDLE.
REQ-026 m_done with m_nack=1 on any WRITE step -> STOP_ERR with err=1.
REQ-027 Timeout counter resets on entering ISSUE or WAIT; reaching TIMEOUT-1 in either state -> STOP_ERR with err=2.
REQ-028 STOP_ERR issues one STOP through the same handshake; on its m_done (or a second timeout) -> ERROR.
REQ-029 ERROR: one cycle, no sample_valid, -> IDLE; acc outputs keep their prior values.
REQ-030 start while busy is ignored and is not queued.
REQ-031 m_done arriving in ISSUE or IDLE is ignored.
REQ-032 m_wdata=8'h00 and m_cmd=4 (STOP) whenever m_valid=0.

Reset
REQ-033 When rst_n is low: FSM=IDLE, step=0, timeout counter=0, m_valid=0, m_cmd=4, m_wdata=0, acc_x/y/z=0, shadow bytes=0, sample_valid=0, busy=0, err=0.
REQ-034 Reset mid-transaction aborts immediately with no STOP issued; the next transaction begins with START.

Verification
REQ-035 Master model acks all commands and returns bytes 34,12,78,56,BC,9A; start pulse -> acc_x=16'h1234, acc_y=16'h5678, acc_z=16'h9ABC, one sample_valid pulse, exactly 12 commands in REQ-019 order.
REQ-036 m_ready held low 20 cycles at every step -> m_valid and m_cmd stay stable; result identical to REQ-035.
REQ-037 Master NACKs WRITE {DEV_ADDR,0} -> one STOP is issued, err=1, no sample_valid, acc outputs keep prior values.
REQ-038 TIMEOUT=100 and m_done withheld on READ_ACK step 7 -> STOP issued at cycle 100 of WAIT, err=2, busy falls.
REQ-039 start pulsed at every cycle during a transaction -> exactly one transaction runs and one sample_valid is produced.
REQ-040 rst_n asserted during step 6 -> all outputs reach REQ-033 values asynchronously; a new start yields a correct full sequence.
